// File: rtl/unidade_controle_jogada.sv
// unidade_controle_jogada: Moore control unit for the memory-game datapath.
//
// Purpose: sequences the datapath address counter (zeraC/contaC) and the key
// register (zeraR/registraR). It registers one play per rising edge of jogada,
// compares the stored keys against the ROM word, and reports the end of the
// round (pronto with acertou, errou or timeout).
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   iniciar             start/restart request (accepted in INICIAL and FIM_*)
//   jogada              play button level; an internal edge detector is used
//   chavesIgualMemoria  datapath flag: keys equal ROM word (informational)
//   fimC                datapath flag: counter at last address
//   fimDiferente        datapath flag: keys differ from ROM word
//   zeraC, contaC       address counter clear / increment
//   zeraR, registraR    key register clear / load
//   pronto, acertou     round finished / round won
//   errou, timeout      round lost / round ended by timeout
//   db_estado           current state code (debug)
//
// Configuration: define TIMEOUT_EN to build the ESPERA timeout counter
// (TIMEOUT_CICLOS cycles, >= 2). Without it FIM_TIMEOUT is unreachable and
// timeout is tied to 0.
module unidade_controle_jogada #(
    parameter int unsigned TIMEOUT_CICLOS = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       chavesIgualMemoria,
    input  logic       fimC,
    input  logic       fimDiferente,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        StInicial    = 4'h0,
        StPreparacao = 4'h1,
        StEspera     = 4'h2,
        StRegistra   = 4'h3,
        StCompara    = 4'h4,
        StProximo    = 4'h5,
        StFimAcertou = 4'hA,
        StFimTimeout = 4'hD,
        StFimErrou   = 4'hE
    } estado_e;

    localparam int unsigned CntW = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;

    estado_e state_q, state_d;
    logic    jogada_q;
    logic    edge_jogada;
    logic    expirou;

    // The equality flag is redundant with fimDiferente for the decision.
    logic unused_igual;
    assign unused_igual = chavesIgualMemoria;

    assign edge_jogada = jogada & ~jogada_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StInicial;
            jogada_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            jogada_q <= jogada;
        end
    end

`ifdef TIMEOUT_EN
    logic [CntW-1:0] cnt_q, cnt_d;

    // Counts only while waiting; any other state restarts the window.
    always_comb begin
        cnt_d = '0;
        if (state_q == StEspera) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expirou = (cnt_q == CntW'(TIMEOUT_CICLOS - 1));
`else
    logic unused_cfg;
    assign unused_cfg = ^CntW;
    assign expirou    = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInicial: begin
                if (iniciar) state_d = StPreparacao;
            end
            StPreparacao: state_d = StEspera;
            StEspera: begin
                // A play in the expiry cycle takes precedence over the timeout.
                if (edge_jogada) begin
                    state_d = StRegistra;
                end else if (expirou) begin
                    state_d = StFimTimeout;
                end
            end
            StRegistra: state_d = StCompara;
            StCompara: begin
                if (fimDiferente) begin
                    state_d = StFimErrou;
                end else if (fimC) begin
                    state_d = StFimAcertou;
                end else begin
                    state_d = StProximo;
                end
            end
            StProximo: state_d = StEspera;
            StFimAcertou, StFimErrou, StFimTimeout: begin
                if (iniciar) state_d = StPreparacao;
            end
            default: state_d = StInicial;
        endcase
    end

    // Moore outputs.
    always_comb begin
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        unique case (state_q)
            StPreparacao: begin
                zeraC = 1'b1;
                zeraR = 1'b1;
            end
            StRegistra:   registraR = 1'b1;
            StProximo:    contaC = 1'b1;
            StFimAcertou: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            StFimErrou: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            StFimTimeout: begin
                pronto  = 1'b1;
                timeout = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = state_q;

endmodule
